dm_store_buffer: RTL
====================

Name: dm_store_buffer

Overview:
- Posted-write store buffer directly upstream of the data memory (DM) in the MEM path.
- Accepts byte, halfword and word stores from the core and turns each into a word-aligned write with byte lane enables and lane-positioned data.
- Queues up to DEPTH stores and drains them to DM one per cycle, with DM-side backpressure.
- Flags loads that hit a pending store word so the core stalls until that store drains.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
PTR_W, 2, pointer width, equals log2(DEPTH)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
St_Valid  in  1  core presents a store
St_Ready  out  1  buffer can accept a store this cycle
St_Addr  in  32  byte address of the store
St_Data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
St_Type  in  2  access width; `type_b / `type_h / `type_w encodings from header.v
St_PC  in  32  PC of the store instruction
St_Err  out  1  registered pulse: the previous cycle's accepted store was misaligned and dropped
Ld_Valid  in  1  core presents a load address this cycle
Ld_Addr  in  32  load byte address
Ld_Stall  out  1  load word address matches a pending entry
DM_WE  out  1  head entry valid; write request to DM
DM_Ready  in  1  DM takes the write this cycle
DM_Addr  out  32  word-aligned address: {head addr[31:2], 2'b00}
DM_BE  out  4  byte enables; bit i covers bits [8i+7:8i]
DM_Data  out  32  lane-positioned write data
DM_PC  out  32  PC of the head entry, for DM write logging
Empty  out  1  no pending entries
Count  out  PTR_W+1  number of pending entries

Behaviour:
- Storage: DEPTH entries of {addr[31:2], BE[3:0], data[31:0], pc[31:0]}. Circular buffer with wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (Reset==0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; St_Err goes to 0.
  - Entry contents need not be cleared.
  - Resulting outputs: St_Ready=1, Empty=1, Count=0, DM_WE=0, Ld_Stall=0.
  - Pending stores are discarded. An in-flight DM handshake in the reset cycle is not completed.
- Accept: St_Valid && St_Ready at a rising edge.
  - St_Ready = (count != DEPTH). It is combinational on count only, with no same-cycle bypass. A full buffer refuses a push even if a pop happens that cycle.
- Entry formation on accept, with a = St_Addr[1:0]:
  - `type_w: BE=4'b1111, data=St_Data. Misaligned if a!=0.
  - `type_h: BE = a[1] ? 4'b1100 : 4'b0011; data = {2{St_Data[15:0]}}. Misaligned if a[0]=1.
  - `type_b: BE = 4'b0001 << a; data = {4{St_Data[7:0]}}.
  - Any other St_Type encoding is treated as `type_w.
- Misaligned accept:
  - The handshake completes; St_Ready is unaffected.
  - No entry is written and count does not change.
  - St_Err=1 on the following cycle for exactly one cycle.
- Drain side:
  - DM_WE = (count != 0).
  - DM_Addr, DM_BE, DM_Data and DM_PC come combinationally from the entry at rd_ptr.
  - At a rising edge with DM_WE && DM_Ready: rd_ptr increments and count decrements.
  - With DM_WE=0, DM_Ready is ignored.
  - DM_Data lanes not enabled by DM_BE carry replicated data; DM must honour DM_BE.
- Simultaneous push and pop in the same edge:
  - count is unchanged; both pointers advance.
  - From count==0 a push is not visible on DM_WE until the next cycle. Minimum store-to-DM latency is 1 cycle.
- Ordering: strict FIFO. Two stores to the same word reach DM in issue order; there is no merging.
- Load hazard:
  - Ld_Stall = Ld_Valid && (some valid entry has addr[31:2] == Ld_Addr[31:2]).
  - Only entries already stored count. A store accepted in the same cycle is excluded; the core never issues a load and a store in the same cycle.
  - Ld_Stall is purely combinational and drops in the cycle after the last matching entry drains.
- Entry validity is derived from rd_ptr and count; there are no per-entry valid bits.
- Full and empty are never ambiguous because count distinguishes 0 from DEPTH.
- Empty = (count==0). Count is the same count value, exported.

Test Plan:
- Reset=0 mid-stream with 3 entries pending -> in the same cycle Empty=1, DM_WE=0, St_Ready=1, Count=0. After Reset=1, no stale entry reaches DM.
- `type_b store, addr 0x0000_0013, data 0x0000_00AB, DM_Ready=1 -> next cycle DM_WE=1, DM_Addr=0x10, DM_BE=4'b1000, DM_Data[31:24]=0xAB; Empty=1 the cycle after.
- `type_h to 0x22 with data 0x1234, then `type_w to 0x24 with data 0xDEADBEEF, DM_Ready=0 -> Count=2. Release DM_Ready: first write DM_Addr=0x20, BE=4'b1100, DM_Data[31:16]=0x1234; then DM_Addr=0x24, BE=4'b1111, DM_Data=0xDEADBEEF.
- Fill with DM_Ready=0 (DEPTH=4) -> St_Ready=0 after the 4th accept and a 5th St_Valid is not taken. DM_Ready=1 with St_Valid held -> one pop frees a slot and the next edge accepts. Wrap-around order preserved over 12 stores.
- Pending store to 0x40 with Ld_Valid=1, Ld_Addr=0x42 -> Ld_Stall=1 until that entry pops. Ld_Addr=0x44 -> Ld_Stall=0.
- `type_w to 0x06 or `type_h to 0x01 -> accepted, Count unchanged, St_Err=1 for exactly one cycle, no DM write.

Source files
------------

// File: rtl/dm_store_buffer.sv
// ============================================================================
// Module      : dm_store_buffer
// Description : Posted-write store buffer in front of data memory. Converts
//               byte/half/word stores into lane-enabled word writes, queues
//               them FIFO-style, and flags loads that hit a pending word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_store_buffer #(
    parameter int         DEPTH  = 4,
    parameter int         PTR_W  = 2,
    parameter logic [1:0] TYPE_B = 2'b00,
    parameter logic [1:0] TYPE_H = 2'b01,
    parameter logic [1:0] TYPE_W = 2'b10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             St_Valid,
    output logic             St_Ready,
    input  logic [31:0]      St_Addr,
    input  logic [31:0]      St_Data,
    input  logic [1:0]       St_Type,
    input  logic [31:0]      St_PC,
    output logic             St_Err,
    input  logic             Ld_Valid,
    input  logic [31:0]      Ld_Addr,
    output logic             Ld_Stall,
    output logic             DM_WE,
    input  logic             DM_Ready,
    output logic [31:0]      DM_Addr,
    output logic [3:0]       DM_BE,
    output logic [31:0]      DM_Data,
    output logic [31:0]      DM_PC,
    output logic             Empty,
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    logic [29:0]      ent_addr [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [3:0]       be_in;
    logic [31:0]      data_in;
    logic             misaligned;
    logic             accept;
    logic             push;
    logic             pop;
    logic             hit;
    logic [PTR_W-1:0] idx;
    logic [1:0]       ld_addr_unused;

    assign ld_addr_unused = Ld_Addr[1:0];

    // Unknown type encodings fall into the word path via the default arm.
    always_comb begin
        be_in      = 4'b1111;
        data_in    = St_Data;
        misaligned = 1'b0;
        case (St_Type)
            TYPE_B: begin
                be_in   = 4'b0001 << St_Addr[1:0];
                data_in = {4{St_Data[7:0]}};
            end
            TYPE_H: begin
                be_in      = St_Addr[1] ? 4'b1100 : 4'b0011;
                data_in    = {2{St_Data[15:0]}};
                misaligned = St_Addr[0];
            end
            default: begin
                be_in      = 4'b1111;
                data_in    = St_Data;
                misaligned = (St_Addr[1:0] != 2'b00);
            end
        endcase
    end

    assign St_Ready = (count != C_FULL);
    assign accept   = St_Valid && St_Ready;
    assign push     = accept && !misaligned;
    assign DM_WE    = (count != '0);
    assign pop      = DM_WE && DM_Ready;
    assign Empty    = (count == '0);
    assign Count    = count;

    assign DM_Addr  = {ent_addr[rd_ptr], 2'b00};
    assign DM_BE    = ent_be[rd_ptr];
    assign DM_Data  = ent_data[rd_ptr];
    assign DM_PC    = ent_pc[rd_ptr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            St_Err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            St_Err <= accept && misaligned;
        end
    end

    // Entry payload needs no reset; validity comes only from rd_ptr/count.
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= St_Addr[31:2];
            ent_be[wr_ptr]   <= be_in;
            ent_data[wr_ptr] <= data_in;
            ent_pc[wr_ptr]   <= St_PC;
        end
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (ent_addr[idx] == Ld_Addr[31:2]))
                hit = 1'b1;
        end
    end

    assign Ld_Stall = Ld_Valid && hit;

endmodule

`default_nettype wire
